// File: rtl/ntt_twiddle_sequencer_pkg.sv
// ntt_twiddle_sequencer_pkg: sequencer states, ROM word field map and shared constants
package ntt_twiddle_sequencer_pkg;
   typedef enum logic [2:0] {IDLE, PRIME, ISSUE_LO, ISSUE_HI, DONE_S} seq_state_e;
   localparam int LO_ZETA_MSB = 31;
   localparam int LO_ZETA_LSB = 16;
   localparam int LO_A_MSB = 15;
   localparam int LO_A_LSB = 8;
   localparam int LO_B_MSB = 7;
   localparam int LO_B_LSB = 0;
   localparam int HI_ZETA_MSB = 63;
   localparam int HI_ZETA_LSB = 48;
   localparam int HI_A_MSB = 47;
   localparam int HI_A_LSB = 40;
   localparam int HI_B_MSB = 39;
   localparam int HI_B_LSB = 32;
   localparam int KYBER_Q = 3329;
endpackage

// File: rtl/ntt_twiddle_sequencer_unpack.sv
// ntt_op_unpack: selects the low or high butterfly command out of one ROM word
module ntt_op_unpack
   import ntt_twiddle_sequencer_pkg::*;
(
   input  logic [63:0] word,
   input  logic        hi,
   output logic [15:0] zeta,
   output logic [7:0]  idx_a,
   output logic [7:0]  idx_b
);
   assign zeta  = hi ? word[HI_ZETA_MSB:HI_ZETA_LSB] : word[LO_ZETA_MSB:LO_ZETA_LSB];
   assign idx_a = hi ? word[HI_A_MSB:HI_A_LSB] : word[LO_A_MSB:LO_A_LSB];
   assign idx_b = hi ? word[HI_B_MSB:HI_B_LSB] : word[LO_B_MSB:LO_B_LSB];
endmodule

// File: rtl/ntt_twiddle_sequencer.sv
// ntt_twiddle_sequencer: walks the twiddle ROM and streams two butterfly commands per word
module ntt_twiddle_sequencer
   import ntt_twiddle_sequencer_pkg::*;
#(
   parameter int NUM_WORDS = 128,
   parameter int ROM_LAT   = 1
) (
   input  logic        clk,
   input  logic        srst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [6:0]  rom_addr,
   input  logic [63:0] rom_dout,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [15:0] op_zeta,
   output logic [7:0]  op_idx_a,
   output logic [7:0]  op_idx_b,
   output logic        op_last
);
   seq_state_e  state_q, state_d;
   logic [6:0]  addr_q, addr_d;
   logic [6:0]  wcnt_q, wcnt_d;
   logic [3:0]  pcnt_q, pcnt_d;
   logic [63:0] word_q, word_d;
   logic        busy_q, busy_d;
   logic        valid, hs, last_word;
   logic [15:0] u_zeta;
   logic [7:0]  u_a, u_b;

   assign valid     = (state_q == ISSUE_LO) || (state_q == ISSUE_HI);
   assign hs        = valid && op_ready;
   assign last_word = wcnt_q == 7'(NUM_WORDS - 1);

   ntt_op_unpack u_unpack (
      .word  (word_q),
      .hi    (state_q == ISSUE_HI),
      .zeta  (u_zeta),
      .idx_a (u_a),
      .idx_b (u_b)
   );

   // next-state: prime the ROM pipeline, then alternate LO/HI issue per word
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wcnt_d  = wcnt_q;
      pcnt_d  = pcnt_q;
      word_d  = word_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = PRIME;
            addr_d  = '0;
            wcnt_d  = '0;
            pcnt_d  = 4'(ROM_LAT);
            busy_d  = 1'b1;
         end
         PRIME: if (pcnt_q == '0) begin
            word_d  = rom_dout;
            addr_d  = 7'd1;
            state_d = ISSUE_LO;
         end else pcnt_d = pcnt_q - 4'd1;
         ISSUE_LO: if (hs) state_d = ISSUE_HI;
         ISSUE_HI: if (hs) begin
            if (last_word) state_d = DONE_S;
            else begin
               word_d  = rom_dout;
               addr_d  = addr_q + 7'd1;
               wcnt_d  = wcnt_q + 7'd1;
               state_d = ISSUE_LO;
            end
         end
         DONE_S: begin
            busy_d  = 1'b0;
            addr_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state register with synchronous abort on srst
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wcnt_q  <= '0;
         pcnt_q  <= '0;
         word_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wcnt_q  <= wcnt_d;
         pcnt_q  <= pcnt_d;
         word_q  <= word_d;
         busy_q  <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign done     = state_q == DONE_S;
   assign rom_addr = addr_q;
   assign op_valid = valid;
   assign op_zeta  = valid ? u_zeta : '0;
   assign op_idx_a = valid ? u_a : '0;
   assign op_idx_b = valid ? u_b : '0;
   assign op_last  = (state_q == ISSUE_HI) && last_word;
endmodule

// File: tb/tb_ntt_twiddle_sequencer.sv
// tb_ntt_twiddle_sequencer: scoreboard bench driving the sequencer from a registered ROM model
module tb_ntt_twiddle_sequencer;
   import ntt_twiddle_sequencer_pkg::*;
   typedef struct packed {logic [15:0] z; logic [7:0] a; logic [7:0] b; logic l;} cmd_t;

   logic clk = 1'b0, srst = 1'b1, start = 1'b0, op_ready = 1'b0;
   logic busy, done, op_valid, op_last;
   logic [6:0] rom_addr;
   logic [63:0] rom_dout = '0;
   logic [15:0] op_zeta;
   logic [7:0] op_idx_a, op_idx_b;
   logic [63:0] rom [128];
   cmd_t exp_q [$];
   cmd_t got [256];
   int checks = 0, failures = 0, cyc = 0, t0 = 0;
   int n_hs = 0, first_rel = -1, done_cnt = 0, done_rel = -1, stall_cyc = 0;
   int rnd = 0, stall_lo = -1, stall_hi = -1;
   logic prev_stall = 1'b0;
   cmd_t prev_cmd = '0;

   ntt_twiddle_sequencer dut (
      .clk(clk), .srst(srst), .start(start), .busy(busy), .done(done),
      .rom_addr(rom_addr), .rom_dout(rom_dout), .op_valid(op_valid), .op_ready(op_ready),
      .op_zeta(op_zeta), .op_idx_a(op_idx_a), .op_idx_b(op_idx_b), .op_last(op_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge clk) rom_dout <= rom[rom_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // monitor: pops the scoreboard on each handshake and checks protocol rules
   always @(negedge clk) begin
      cmd_t c;
      c = {op_zeta, op_idx_a, op_idx_b, op_last};
      if (prev_stall) begin
         chk("stall_valid", 64'(op_valid), 64'd1);
         chk("stall_hold", 64'(c), 64'(prev_cmd));
      end
      if (op_valid) begin
         chk("zeta_lt_q", 64'(op_zeta < 16'(KYBER_Q)), 64'd1);
         if (!op_ready) stall_cyc++;
         else begin
            if (n_hs == 0) first_rel = cyc - t0;
            if (n_hs < 256) got[n_hs] = c;
            n_hs++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_extra: unexpected command %h", c);
            end else chk("sb_cmd", 64'(c), 64'(exp_q.pop_front()));
         end
      end else chk("idle_zero", 64'(c), 64'd0);
      if (done) begin
         done_cnt++;
         done_rel = cyc - t0;
      end
      prev_stall = op_valid && !op_ready && !srst;
      prev_cmd = c;
   end

   task automatic set_ready();
      op_ready = rnd != 0 ? 1'($urandom_range(0, 1)) :
                 !((cyc - t0) >= stall_lo && (cyc - t0) <= stall_hi);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      start = 1'b0;
      set_ready();
   endtask

   task automatic begin_pass();
      n_hs = 0; done_cnt = 0; done_rel = -1; first_rel = -1; stall_cyc = 0;
      for (int w = 0; w < 128; w++) begin
         exp_q.push_back({rom[w][31:16], rom[w][15:8], rom[w][7:0], 1'b0});
         exp_q.push_back({rom[w][63:48], rom[w][47:40], rom[w][39:32], w == 127});
      end
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b1;
      set_ready();
   endtask

   task automatic wait_done(input int bound, input string name);
      for (int i = 0; i < bound && done_cnt == 0; i++) tick();
      if (done_cnt == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: no done within %0d cycles", name, bound);
      end
      repeat (5) tick();
      chk({name, "_done_count"}, 64'(done_cnt), 64'd1);
      chk({name, "_busy_after"}, 64'(busy), 64'd0);
      chk({name, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int w = 0; w < 128; w++)
         rom[w] = {16'(2000 + 7 * w), 8'(w), 8'(w + 32), 16'(100 + 23 * w), 8'(w), 8'(w + 8)};
      rom[0]   = {16'h0c37, 8'h00, 8'h20, 16'h023d, 8'h00, 8'h08};
      rom[1][31:0]  = {16'h023d, 8'h01, 8'h09};
      rom[8][63:32] = {16'h0c37, 8'h08, 8'h28};
      rom[9][31:0]  = {16'h07d4, 8'h11, 8'h19};
      rom[127] = {16'h072c, 8'hdf, 8'hff, 16'h06de, 8'hf7, 8'hff};
      repeat (3) tick();
      chk("rst_valid", 64'(op_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_addr", 64'(rom_addr), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b1;
      tick();
      chk("start_in_reset_busy", 64'(busy), 64'd0);
      srst = 1'b0;
      tick();

      // unstalled pass: latency and hand-computed commands
      begin_pass();
      tick();
      chk("busy_after_start", 64'(busy), 64'd1);
      wait_done(400, "passA");
      chk("first_valid_cycle", 64'(first_rel), 64'd3);
      chk("cmd0", 64'(got[0]), 64'({16'h023d, 8'h00, 8'h08, 1'b0}));
      chk("cmd1", 64'(got[1]), 64'({16'h0c37, 8'h00, 8'h20, 1'b0}));
      chk("cmd2", 64'(got[2]), 64'({16'h023d, 8'h01, 8'h09, 1'b0}));
      chk("cmd254", 64'(got[254]), 64'({16'h06de, 8'hf7, 8'hff, 1'b0}));
      chk("cmd255", 64'(got[255]), 64'({16'h072c, 8'hdf, 8'hff, 1'b1}));
      chk("passA_handshakes", 64'(n_hs), 64'd256);
      chk("passA_done_cycle", 64'(done_rel), 64'd259);

      // random backpressure
      rnd = 1;
      begin_pass();
      wait_done(1500, "rand");
      rnd = 0;
      chk("rand_handshakes", 64'(n_hs), 64'd256);

      // 20-cycle stall on word 8 HI
      stall_lo = 20;
      stall_hi = 39;
      begin_pass();
      wait_done(500, "stall");
      stall_lo = -1;
      stall_hi = -1;
      chk("stall_cycles", 64'(stall_cyc), 64'd20);
      chk("stall_held_cmd", 64'(got[17]), 64'({16'h0c37, 8'h08, 8'h28, 1'b0}));
      chk("stall_next_cmd", 64'(got[18]), 64'({16'h07d4, 8'h11, 8'h19, 1'b0}));
      chk("stall_done_cycle", 64'(done_rel), 64'd279);

      // abort with srst while command 100 is presented
      begin_pass();
      repeat (103) tick();
      srst = 1'b1;
      tick();
      srst = 1'b0;
      chk("abort_valid", 64'(op_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_addr", 64'(rom_addr), 64'd0);
      repeat (10) tick();
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_handshakes", 64'(n_hs), 64'd101);
      exp_q.delete();
      begin_pass();
      wait_done(400, "restart");
      chk("restart_cmd0", 64'(got[0]), 64'({16'h023d, 8'h00, 8'h08, 1'b0}));
      chk("restart_handshakes", 64'(n_hs), 64'd256);

      // start re-pulsed while busy
      begin_pass();
      repeat (50) tick();
      start = 1'b1;
      wait_done(400, "repulse");
      chk("repulse_done_cycle", 64'(done_rel), 64'd259);
      chk("repulse_handshakes", 64'(n_hs), 64'd256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ntt_twiddle_sequencer.md
Name: ntt_twiddle_sequencer

Overview:
- Reader/consumer side of the 128×64-bit NTT twiddle/index ROM (`rom_gen_*` family).
- On `start`, it walks ROM addresses 0..NUM_WORDS-1 and absorbs the ROM's registered 1-cycle read latency.
- Each ROM word is unpacked into two butterfly commands (low half first, then high half).
- Commands stream to the butterfly datapath over a valid/ready handshake. At `op_ready`=1 the throughput is one command per cycle.

Parameters:
- NUM_WORDS, 128, number of ROM words per pass; `rom_addr` width is 7.
- ROM_LAT, 1, ROM read latency in cycles after `rom_addr` is stable.

Ports:
- clk  input  1  clock
- srst  input  1  synchronous reset, active-high
- start  input  1  single-cycle pulse that begins a pass; ignored unless IDLE
- busy  output  1  high from the cycle after `start` until `done`
- done  output  1  one-cycle pulse after the final handshake
- rom_addr  output  7  registered ROM address
- rom_dout  input  64  ROM data, valid ROM_LAT cycles after `rom_addr` settles
- op_valid  output  1  command valid
- op_ready  input  1  downstream accepts the command
- op_zeta  output  16  twiddle factor
- op_idx_a  output  8  butterfly upper coefficient index
- op_idx_b  output  8  butterfly lower coefficient index
- op_last  output  1  marks the final command of a pass

Behaviour:
- Reset: clock is `clk`; reset is `srst`, synchronous, active-high.
  - All outputs 0; `rom_addr`=0; word_q=0; state IDLE.
  - `srst` mid-pass aborts immediately. No `done` is produced and no further `op_valid`.
- Word format:
  - LO command: zeta=[31:16], idx_a=[15:8], idx_b=[7:0].
  - HI command: zeta=[63:48], idx_a=[47:40], idx_b=[39:32].
  - Fields pass through unmodified; no arithmetic.
- States: IDLE, PRIME, ISSUE_LO, ISSUE_HI, DONE_S.
- IDLE → PRIME on `start`:
  - Set `rom_addr`<=0, wcnt<=0, prime counter<=ROM_LAT, `busy`<=1.
- PRIME:
  - Lasts ROM_LAT+1 cycles (2 by default).
  - In its final cycle, capture word_q<=`rom_dout` (word 0), set `rom_addr`<=1, then go to ISSUE_LO.
- ISSUE_LO:
  - `op_valid`=1 with the LO fields of word_q.
  - On `op_valid`&`op_ready` → ISSUE_HI.
- ISSUE_HI:
  - `op_valid`=1 with the HI fields of word_q.
  - On handshake with wcnt≠NUM_WORDS-1:
    - word_q<=`rom_dout`, `rom_addr`<=`rom_addr`+1, wcnt++, → ISSUE_LO.
    - `rom_dout` is guaranteed valid at this point, since at least ROM_LAT+1 cycles have elapsed since the last address change.
  - On handshake with wcnt=NUM_WORDS-1: → DONE_S.
- `op_last`=1 only in ISSUE_HI with wcnt=NUM_WORDS-1.
- DONE_S: `done`=1 for one cycle, `busy`<=0, `rom_addr`<=0, → IDLE.
- Backpressure: while `op_valid`=1 and `op_ready`=0, `op_zeta`/`op_idx_a`/`op_idx_b`/`op_last` hold stable and the state holds.
- `op_valid` never drops without a handshake.
- When `op_valid`=0, the `op_*` data outputs are 0.
- `start` while busy is ignored.
- `start` coincident with `srst`: reset wins.
- `rom_addr` increment is 7-bit. It never exceeds NUM_WORDS-1 during a pass; the last word does not trigger a fetch.
- Latency with `op_ready`=1 and `start` in cycle 0:
  - first `op_valid` in cycle 3;
  - 2·NUM_WORDS commands in consecutive cycles 3..258;
  - `done` in cycle 259.

Decomposition:
- Shared package:
  - state enum;
  - field bit positions (LO_ZETA_MSB/LSB, LO_A, LO_B, HI_ZETA, HI_A, HI_B);
  - KYBER_Q=3329 constant for assertions (every zeta < Q).
- One sub-module is natural: `ntt_op_unpack`, a combinational half-select of word_q into zeta/idx_a/idx_b. All sequencing stays in the top module.

Test Plan:
- Reset, then `start` in cycle 0 with `op_ready`=1:
  - cycle 3: `op_valid`, zeta=0x023d, a=0x00, b=0x08;
  - cycle 4: zeta=0x0c37, a=0x00, b=0x20;
  - cycle 5: word 1 LO, zeta=0x023d, a=0x01, b=0x09.
- Full pass with `op_ready`=1:
  - exactly 256 handshakes;
  - command 254: zeta=0x06de, a=0xf7, b=0xff;
  - command 255: zeta=0x072c, a=0xdf, b=0xff, `op_last`=1;
  - `done` pulses once in cycle 259; `busy` is 0 afterwards.
- Random `op_ready` (50%):
  - outputs stay stable while stalled;
  - the command sequence is identical to the unstalled run;
  - `rom_addr` never exceeds 0x7f;
  - every zeta < 3329.
- `op_ready`=0 for 20 cycles at ISSUE_HI of word 0x08, then released:
  - HI command zeta=0x0c37, a=0x08, b=0x28 is held for all 20 cycles;
  - the next command is zeta=0x07d4, a=0x11, b=0x19.
- `srst` asserted mid-pass at command 100:
  - next cycle `op_valid`=0, `busy`=0, `rom_addr`=0, no `done`;
  - a new `start` restarts from word 0.
- `start` re-pulsed while busy: ignored, sequence unaffected, exactly one `done`.
